lru_age_table: RTL

Per-set LRU replacement state for the N-way set-associative cache. Holds a WAYS-entry age vector for every set, applies the age-update rule on each hit/fill, and returns the least-recently-used way for victim selection with one cycle of latency. Also provides a multi-cycle flush sequencer and, optionally, per-way invalidation. Sits beside the tag array; the cache controller drives accesses and victim queries.

---
 rtl/lru_age_table.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lru_age_table.sv
// lru_age_table: per-set LRU age vectors, one-cycle victim lookup and a SETS-cycle flush sequencer.
// Per-way invalidation (inv_* ports and logic) is compiled in only when LRU_INVALIDATE_EN is defined.
module lru_age_table #(
  parameter int WAYS = 4,
  parameter int SETS = 64,
  parameter int AW   = $clog2(WAYS),
  parameter int SW   = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_valid,
  input  logic [SW-1:0] acc_set,
  input  logic [AW-1:0] acc_way,
  output logic          acc_ready,
  input  logic          vq_valid,
  input  logic [SW-1:0] vq_set,
  output logic          victim_valid,
  output logic [AW-1:0] victim_way,
  input  logic          flush_req,
`ifdef LRU_INVALIDATE_EN
  input  logic          inv_valid,
  input  logic [SW-1:0] inv_set,
  input  logic [AW-1:0] inv_way,
`endif
  output logic          busy
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state;
  logic [SW-1:0] cnt;

  // age[s][w]: 0 = LRU, WAYS-1 = MRU; every row is a permutation of 0..WAYS-1
  logic [AW-1:0] age [SETS][WAYS];

  logic          acc_fire;
  logic [AW-1:0] acc_old;
  logic [AW-1:0] acc_row [WAYS];
  logic [AW-1:0] vq_way;

  // NOTE: every always_comb output gets a default before any conditional, so no latch is inferred.
  always_comb begin
    acc_fire = acc_valid && acc_ready;
    acc_old  = age[acc_set][acc_way];
    for (int w = 0; w < WAYS; w++) begin
      acc_row[w] = age[acc_set][w];
      if (AW'(w) == acc_way)
        acc_row[w] = AW'(WAYS - 1);
      else if (age[acc_set][w] > acc_old)
        acc_row[w] = age[acc_set][w] - AW'(1);
    end
  end

`ifdef LRU_INVALIDATE_EN
  logic          inv_fire;
  logic [AW-1:0] inv_old;
  logic [AW-1:0] inv_row [WAYS];

  // An access to the same set wins; the invalidate is dropped.
  always_comb begin
    inv_fire = inv_valid && acc_ready && !(acc_fire && (inv_set == acc_set));
    inv_old  = age[inv_set][inv_way];
    for (int w = 0; w < WAYS; w++) begin
      inv_row[w] = age[inv_set][w];
      if (AW'(w) == inv_way)
        inv_row[w] = '0;
      else if (age[inv_set][w] < inv_old)
        inv_row[w] = age[inv_set][w] + AW'(1);
    end
  end
`endif

  always_comb begin
    vq_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[vq_set][w] == '0) vq_way = AW'(w);
  end

  // NOTE: the table is reset as flops, not an SRAM, because reset itself must leave every set initialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AW'(w);
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (state == FLUSH && cnt == SW'(s)) begin
          for (int w = 0; w < WAYS; w++) age[s][w] <= AW'(w);
        end else if (acc_fire && acc_set == SW'(s)) begin
          for (int w = 0; w < WAYS; w++) age[s][w] <= acc_row[w];
`ifdef LRU_INVALIDATE_EN
        end else if (inv_fire && inv_set == SW'(s)) begin
          for (int w = 0; w < WAYS; w++) age[s][w] <= inv_row[w];
`endif
        end
      end
    end
  end

  // NOTE: non-blocking updates mean a same-edge query sees the table as it was before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      acc_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (flush_req) begin
          state     <= FLUSH;
          cnt       <= '0;
          busy      <= 1'b1;
          acc_ready <= 1'b0;
        end
        FLUSH: if (cnt == SW'(SETS - 1)) begin
          state     <= IDLE;
          cnt       <= '0;
          busy      <= 1'b0;
          acc_ready <= 1'b1;
        end else begin
          cnt <= cnt + SW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= vq_valid;
      if (vq_valid) victim_way <= vq_way;
    end
  end

endmodule
